// File: rtl/ft_pkg.sv
// Shared types and constants for the fault-tolerance recovery engine.
package ft_pkg;

    typedef enum logic [2:0] {
        FT_REC_IDLE,
        FT_REC_COPY,
        FT_REC_DRAIN,
        FT_REC_PC,
        FT_REC_DONE
    } ft_rec_state_e;

    // x0 is hard-wired zero in the cores, so copying starts at x1.
    localparam int unsigned FT_REG_FIRST = 1;

    // States in which a drop of the controller's recovering phase is an abort.
    function automatic logic ft_rec_active(input ft_rec_state_e s);
        return (s == FT_REC_COPY) || (s == FT_REC_DRAIN) || (s == FT_REC_PC);
    endfunction

endpackage

// File: rtl/ft_recovery_if.sv
// Register-file and PC debug-port bundle between the recovery engine and the cores.
interface ft_recovery_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] rf_raddr_o;
    logic [DATA_WIDTH-1:0] rf_rdata_i;
    logic                  rf_we_o;
    logic [ADDR_WIDTH-1:0] rf_waddr_o;
    logic [DATA_WIDTH-1:0] rf_wdata_o;
    logic [DATA_WIDTH-1:0] pc_i;
    logic                  pc_we_o;
    logic [DATA_WIDTH-1:0] pc_o;

    // Recovery engine side.
    modport master (
        output rf_raddr_o,
        input  rf_rdata_i,
        output rf_we_o,
        output rf_waddr_o,
        output rf_wdata_o,
        input  pc_i,
        output pc_we_o,
        output pc_o
    );

    // Core debug-port side.
    modport slave (
        input  rf_raddr_o,
        output rf_rdata_i,
        input  rf_we_o,
        input  rf_waddr_o,
        input  rf_wdata_o,
        output pc_i,
        input  pc_we_o,
        input  pc_o
    );

endinterface

// File: rtl/ft_recovery.sv
// Recovery engine: copies x1..x(NREGS-1) from the source core into the destination core,
// optionally restores the PC (macro FT_PC_RESTORE_EN), then holds done until the controller releases it.
module ft_recovery
    import ft_pkg::*;
#(
    parameter int NREGS      = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          recover_i,
    input  logic          recovering_i,
    output logic          busy_o,
    output logic          recovery_done_o,
    ft_recovery_if.master rf_bus
);

    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(FT_REG_FIRST);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NREGS - 1);

    ft_rec_state_e         r_state;
    ft_rec_state_e         w_state_next;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_next;
    logic                  r_recover_q;
    logic                  w_start;
    logic                  w_abort;
    logic                  w_issue;

    logic                  r_rd_vld;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_busy;
    logic                  r_done;

    // Only a rising request starts a transaction, so a held level cannot restart after DONE.
    assign w_start = recover_i & ~r_recover_q;
    assign w_abort = ft_rec_active(r_state) & ~recovering_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= FT_REC_IDLE;
            r_cnt       <= '0;
            r_recover_q <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_recover_q <= recover_i;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_issue      = 1'b0;
        case (r_state)
            FT_REC_IDLE: begin
                if (w_start) begin
                    w_state_next = FT_REC_COPY;
                    w_cnt_next   = FIRST_ADDR;
                end
            end
            FT_REC_COPY: begin
                w_issue = 1'b1;
                // Hold the counter on the last address so it never wraps back onto x0.
                if (r_cnt == LAST_ADDR) begin
                    w_state_next = FT_REC_DRAIN;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            FT_REC_DRAIN: begin
`ifdef FT_PC_RESTORE_EN
                w_state_next = FT_REC_PC;
`else
                w_state_next = FT_REC_DONE;
`endif
            end
            FT_REC_PC: begin
                w_state_next = FT_REC_DONE;
            end
            FT_REC_DONE: begin
                if (!recovering_i) begin
                    w_state_next = FT_REC_IDLE;
                end
            end
            default: begin
                w_state_next = FT_REC_IDLE;
            end
        endcase
        if (w_abort) begin
            w_state_next = FT_REC_IDLE;
            w_issue      = 1'b0;
        end
        if (w_state_next == FT_REC_IDLE) begin
            w_cnt_next = '0;
        end
    end

    // Write stage trails the read by one cycle: source data arrives the cycle after its address.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_vld  <= 1'b0;
            r_rd_addr <= '0;
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_rd_vld  <= w_issue;
            r_rd_addr <= r_cnt;
            r_we      <= r_rd_vld & ~w_abort;
            if (r_rd_vld && !w_abort) begin
                r_waddr <= r_rd_addr;
                r_wdata <= rf_bus.rf_rdata_i;
            end
            r_busy    <= (r_state != FT_REC_IDLE);
            r_done    <= (r_state == FT_REC_DONE);
        end
    end

    assign rf_bus.rf_raddr_o = r_cnt;
    assign rf_bus.rf_we_o    = r_we;
    assign rf_bus.rf_waddr_o = r_waddr;
    assign rf_bus.rf_wdata_o = r_wdata;
    assign busy_o            = r_busy;
    assign recovery_done_o   = r_done;

`ifdef FT_PC_RESTORE_EN
    logic                  r_pc_we;
    logic [DATA_WIDTH-1:0] r_pc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pc_we <= 1'b0;
            r_pc    <= '0;
        end else begin
            r_pc_we <= (r_state == FT_REC_PC) & ~w_abort;
            if ((r_state == FT_REC_PC) && !w_abort) begin
                r_pc <= rf_bus.pc_i;
            end
        end
    end

    assign rf_bus.pc_we_o = r_pc_we;
    assign rf_bus.pc_o    = r_pc;
`else
    logic w_pc_unused;

    assign w_pc_unused    = ^rf_bus.pc_i;
    assign rf_bus.pc_we_o = 1'b0;
    assign rf_bus.pc_o    = '0;
`endif

endmodule
